// File: rtl/split_assign_gen.sv
// Candidate-assignment generator for split-constraint checkers: walks an
// exhaustive counter or an LFSR, checks one candidate per cycle, forwards hits.
module split_assign_gen #(
  parameter int               VEC_W = 32,
  parameter logic [VEC_W-1:0] TAPS  = VEC_W'(32'h8020_0003),
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [VEC_W-1:0] seed,
  input  logic [CNT_W-1:0] max_tries,
  input  logic [CNT_W-1:0] num_sol,
  output logic [VEC_W-1:0] cand,
  output logic             cand_valid,
  input  logic             sat_in,
  output logic [VEC_W-1:0] sol_data,
  output logic             sol_valid,
  input  logic             sol_ready,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             exhausted,
  output logic [CNT_W-1:0] try_cnt,
  output logic [CNT_W-1:0] sol_cnt
);

  typedef enum logic [1:0] {IDLE, GEN, EMIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [VEC_W-1:0] cand_q, cand_next, sol_q;
  logic             mode_q;
  logic [CNT_W-1:0] max_q, num_q, try_q, sol_cnt_q;
  logic [CNT_W-1:0] try_inc, sol_inc;
  logic             fail_q, exh_q;
  logic             space_end;

  // FSM control strobes
  logic load, adv, take, finish, fail_set;

  assign try_inc   = (try_q == '1) ? try_q : try_q + 1'b1;
  assign sol_inc   = (sol_cnt_q == '1) ? sol_cnt_q : sol_cnt_q + 1'b1;
  assign space_end = !mode_q && (cand_q == '1);
  assign cand_next = mode_q ? {cand_q[VEC_W-2:0], ^(cand_q & TAPS)} : cand_q + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    adv      = 1'b0;
    take     = 1'b0;
    finish   = 1'b0;
    fail_set = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = GEN;
        end
      end
      GEN: begin
        if (sat_in) begin
          take    = 1'b1;
          state_d = EMIT;
        end else begin
          adv = 1'b1;
          if (try_inc == max_q || space_end) begin
            finish   = 1'b1;
            fail_set = 1'b1;
            state_d  = DONE;
          end
        end
      end
      EMIT: begin
        if (sol_ready) begin
          adv = 1'b1;
          // Quota beats budget beats exhaustion.
          if (sol_inc == num_q) begin
            finish  = 1'b1;
            state_d = DONE;
          end else if (try_q == max_q || space_end) begin
            finish   = 1'b1;
            fail_set = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = GEN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      sol_q     <= '0;
      mode_q    <= 1'b0;
      max_q     <= '0;
      num_q     <= '0;
      try_q     <= '0;
      sol_cnt_q <= '0;
      fail_q    <= 1'b0;
      exh_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        // An all-zero LFSR state would lock up, so mode 1 substitutes 1.
        cand_q    <= (mode && seed == '0) ? VEC_W'(1) : seed;
        mode_q    <= mode;
        max_q     <= (max_tries == '0) ? CNT_W'(1) : max_tries;
        num_q     <= (num_sol == '0) ? CNT_W'(1) : num_sol;
        try_q     <= '0;
        sol_cnt_q <= '0;
        fail_q    <= 1'b0;
        exh_q     <= 1'b0;
      end else begin
        if (state_q == GEN) try_q <= try_inc;
        if (take) sol_q <= cand_q;
        if (state_q == EMIT && sol_ready) sol_cnt_q <= sol_inc;
        if (adv) cand_q <= cand_next;
        if (finish) begin
          fail_q <= fail_set;
          exh_q  <= space_end;
        end
      end
    end
  end

  assign cand       = cand_q;
  assign cand_valid = (state_q == GEN);
  assign sol_data   = sol_q;
  assign sol_valid  = (state_q == EMIT);
  assign busy       = (state_q == GEN) || (state_q == EMIT);
  assign done       = (state_q == DONE);
  assign fail       = fail_q;
  assign exhausted  = exh_q;
  assign try_cnt    = try_q;
  assign sol_cnt    = sol_cnt_q;

endmodule
